// File: rtl/clk_rst_gen.sv
// clk_rst_gen: divided clock with programmable period/duty plus a delayed, synchronised active-low reset
module clk_rst_gen #(
  parameter int PERIOD = 5,
  parameter int DUTY   = 50,
  parameter int DELAY  = 996
) (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic clk_out_o,
  output logic tick_o,
  output logic rst_n_out_o,
  output logic busy_o
);
  if (PERIOD < 2 || DUTY < 1 || DUTY > 99 || DELAY < 0 || DELAY > 65535) begin : g_bad_param
    $error("clk_rst_gen: illegal parameter PERIOD=%0d DUTY=%0d DELAY=%0d", PERIOD, DUTY, DELAY);
  end
  localparam int HRAW = PERIOD * DUTY / 100;
  localparam int HIGH = HRAW < 1 ? 1 : (HRAW > PERIOD - 1 ? PERIOD - 1 : HRAW);
  localparam int PW = PERIOD > 2 ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] HI = PW'(HIGH);
  localparam logic [15:0] DLY = 16'(DELAY);
  logic [PW-1:0] phase_q, phase_d;
  logic [15:0] dcnt_q, dcnt_d;
  logic clk_out_q, clk_out_d, tick_q, tick_d, s1_q, s2_q;
  logic rst_out_q, rst_out_d, busy_q, busy_d;
  // next state: release and busy are evaluated on the post-edge synchroniser and counter values
  always_comb begin
    phase_d   = phase_q == LAST ? '0 : phase_q + 1'b1;
    clk_out_d = phase_q < HI;
    tick_d    = phase_q == '0;
    dcnt_d    = (s2_q && dcnt_q < DLY) ? dcnt_q + 16'd1 : dcnt_q;
    rst_out_d = s1_q & (dcnt_d == DLY);
    busy_d    = s1_q & ~rst_out_d;
  end
  // every flop clears asynchronously so outputs drop without a clk edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      dcnt_q    <= '0;
      rst_out_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      s1_q      <= 1'b1;
      s2_q      <= s1_q;
      dcnt_q    <= dcnt_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
    end
  end
  assign clk_out_o   = clk_out_q;
  assign tick_o      = tick_q;
  assign rst_n_out_o = rst_out_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_clk_rst_gen.sv
// tb_clk_rst_gen: scoreboard bench running four parameter sets side by side against an edge-count model
module tb_clk_rst_gen;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic go = 1'b0;
  logic [3:0] c, t, r, b;
  logic [15:0] sb[$];
  int checks = 0, failures = 0, k = 0;
  int pp[4] = '{5, 4, 4, 7};
  int du[4] = '{50, 10, 99, 30};
  int dd[4] = '{996, 0, 3, 20};

  always #5 clk_i = ~clk_i;

  clk_rst_gen #(.PERIOD(5), .DUTY(50), .DELAY(996)) u0 (.clk_i(clk_i), .rst_n_i(rst_n_i),
    .clk_out_o(c[0]), .tick_o(t[0]), .rst_n_out_o(r[0]), .busy_o(b[0]));
  clk_rst_gen #(.PERIOD(4), .DUTY(10), .DELAY(0)) u1 (.clk_i(clk_i), .rst_n_i(rst_n_i),
    .clk_out_o(c[1]), .tick_o(t[1]), .rst_n_out_o(r[1]), .busy_o(b[1]));
  clk_rst_gen #(.PERIOD(4), .DUTY(99), .DELAY(3)) u2 (.clk_i(clk_i), .rst_n_i(rst_n_i),
    .clk_out_o(c[2]), .tick_o(t[2]), .rst_n_out_o(r[2]), .busy_o(b[2]));
  clk_rst_gen #(.PERIOD(7), .DUTY(30), .DELAY(20)) u3 (.clk_i(clk_i), .rst_n_i(rst_n_i),
    .clk_out_o(c[3]), .tick_o(t[3]), .rst_n_out_o(r[3]), .busy_o(b[3]));

  // outputs after edge k (k = edges with rst_n high since release, 0 while in reset): {busy, rst_n_out, tick, clk_out}
  function automatic logic [3:0] model(int kk, int p, int d, int dt);
    int h = p * dt / 100;
    if (h < 1) h = 1;
    if (h > p - 1) h = p - 1;
    if (kk == 0) return 4'b0;
    return {kk >= 2 && kk <= d + 1, kk >= d + 2, (kk - 1) % p == 0, (kk - 1) % p < h};
  endfunction

  function automatic logic [15:0] expect_all(int kk);
    logic [15:0] e;
    for (int i = 0; i < 4; i++) e[i*4 +: 4] = model(kk, pp[i], dd[i], du[i]);
    return e;
  endfunction

  // one clk cycle: queue the expectation for the coming rising edge, then return at the falling edge
  task automatic cyc();
    int kn = rst_n_i ? k + 1 : 0;
    sb.push_back(expect_all(kn));
    @(posedge clk_i);
    k = kn;
    @(negedge clk_i);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // async assert just after a falling edge; short pulses release before the next rising edge
  task automatic do_reset(bit short_pulse, int hold);
    #1;
    sb.push_back(16'h0);
    rst_n_i = 1'b0;
    k = 0;
    if (short_pulse) begin
      #3 rst_n_i = 1'b1;
    end else begin
      run(hold);
      rst_n_i = 1'b1;
    end
  endtask

  // monitor: compare on every rising edge and every reset assertion
  always @(posedge clk_i or negedge rst_n_i) begin
    if (go) begin
      logic [15:0] act, exp_v;
      #1;
      for (int i = 0; i < 4; i++) act[i*4 +: 4] = {b[i], r[i], t[i], c[i]};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL underflow: output event at %0t with no expectation queued, actual=%h", $time, act);
      end else begin
        exp_v = sb.pop_front();
        if (act !== exp_v) begin
          failures++;
          $display("FAIL outputs at %0t k=%0d: actual=%h required=%h", $time, k, act, exp_v);
        end
      end
    end
  end

  initial begin
    #1 go = 1'b1;
    run(3);
    rst_n_i = 1'b1;
    run(1010);
    run(($urandom_range(0, 4) * 5) + 2);
    do_reset(1'b0, 2);
    run(503);
    do_reset(1'b0, 1);
    run(1000);
    do_reset(1'b1, 0);
    run(1000);
    for (int s = 0; s < 25; s++) begin
      run($urandom_range(1, 40));
      do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
    end
    run(30);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations never matched by an output event, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
